// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - MEM-stage load/store controller in front of a 16-bit data_memory
// One request at a time: word/byte loads, word stores, byte stores via read-modify-write.
module load_store_unit #(
  parameter int DEPTH_WORDS = 256
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic        req_byte,
  input  logic        req_signed,
  input  logic [15:0] req_addr,
  input  logic [15:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [15:0] resp_rdata,
  output logic        resp_err,
  output logic [15:0] address,
  output logic [15:0] write_data,
  output logic        mem_read,
  output logic        mem_write,
  input  logic [15:0] read_data
);

  localparam logic [15:0] DEPTH_LIM = 16'(DEPTH_WORDS);

  typedef enum logic [2:0] {
    IDLE, READ, CAPTURE, RMW_READ, RMW_MERGE, WRITE, RESP
  } state_t;

  state_t      state;
  logic        we_q, byte_q, signed_q;
  logic [15:0] addr_q, wdata_q;

  logic [15:0] req_word;
  logic        req_bad;
  logic [7:0]  lane;
  logic [15:0] load_fmt, merge;

  assign req_word = {1'b0, req_addr[15:1]};
  assign req_bad  = (!req_byte && req_addr[0]) || (req_word >= DEPTH_LIM);

  // Byte lanes are little-endian: addr[0] picks the high byte.
  assign lane = addr_q[0] ? read_data[15:8] : read_data[7:0];

  always_comb begin
    load_fmt = read_data;
    if (byte_q) load_fmt = signed_q ? {{8{lane[7]}}, lane} : {8'h00, lane};
  end

  always_comb begin
    merge = wdata_q;
    if (byte_q) merge = addr_q[0] ? {wdata_q[7:0], read_data[7:0]} : {read_data[15:8], wdata_q[7:0]};
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
      address    <= '0;
      write_data <= '0;
      mem_read   <= 1'b0;
      mem_write  <= 1'b0;
      we_q       <= 1'b0;
      byte_q     <= 1'b0;
      signed_q   <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid && req_ready) begin
            we_q      <= req_we;
            byte_q    <= req_byte;
            signed_q  <= req_signed;
            addr_q    <= req_addr;
            wdata_q   <= req_wdata;
            req_ready <= 1'b0;
            if (req_bad) begin
              state      <= RESP;
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
              resp_rdata <= '0;
            end else if (!req_we) begin
              state    <= READ;
              mem_read <= 1'b1;
              address  <= req_word;
            end else if (req_byte) begin
              state    <= RMW_READ;
              mem_read <= 1'b1;
              address  <= req_word;
            end else begin
              state      <= WRITE;
              mem_write  <= 1'b1;
              address    <= req_word;
              write_data <= req_wdata;
            end
          end
        end
        READ: begin
          mem_read <= 1'b0;
          address  <= '0;
          state    <= CAPTURE;
        end
        CAPTURE: begin
          resp_rdata <= we_q ? 16'h0000 : load_fmt;
          resp_valid <= 1'b1;
          state      <= RESP;
        end
        RMW_READ: begin
          mem_read <= 1'b0;
          address  <= '0;
          state    <= RMW_MERGE;
        end
        RMW_MERGE: begin
          mem_write  <= 1'b1;
          address    <= {1'b0, addr_q[15:1]};
          write_data <= merge;
          state      <= WRITE;
        end
        WRITE: begin
          mem_write  <= 1'b0;
          address    <= '0;
          write_data <= '0;
          resp_valid <= 1'b1;
          resp_rdata <= '0;
          state      <= RESP;
        end
        RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
            req_ready  <= 1'b1;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - self-checking bench for load_store_unit
// Transaction-level reference model plus a per-cycle output compare and directed literal checks.
module tb_load_store_unit;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0, req_we = 1'b0, req_byte = 1'b0, req_signed = 1'b0;
  logic [15:0] req_addr = '0, req_wdata = '0;
  logic        resp_ready = 1'b1;
  logic        req_ready, resp_valid, resp_err, mem_read, mem_write;
  logic [15:0] resp_rdata, address, write_data;
  logic [15:0] read_data = '0;

  int tests = 0;
  int fails = 0;

  load_store_unit #(.DEPTH_WORDS(256)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_byte(req_byte),
    .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .address(address), .write_data(write_data), .mem_read(mem_read), .mem_write(mem_write),
    .read_data(read_data)
  );

  always #5 clock = ~clock;

  // data_memory stand-in (no reset) and bus activity log
  logic [15:0] dmem [256];
  logic [15:0] last_wr_addr = '0, last_wr_data = '0;
  int n_rd = 0, n_wr = 0;

  always @(posedge clock) begin
    if (mem_write) begin
      dmem[address[7:0]] <= write_data;
      last_wr_addr <= address;
      last_wr_data <= write_data;
      n_wr <= n_wr + 1;
    end
    if (mem_read) begin
      read_data <= dmem[address[7:0]];
      n_rd <= n_rd + 1;
    end
  end

  function automatic void chk16(input string name, input logic [15:0] got, input logic [15:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h at %0t", name, got, exp, $time);
    end
  endfunction

  function automatic void chk1(input string name, input logic got, input logic exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %b, expected %b at %0t", name, got, exp, $time);
    end
  endfunction

  function automatic void chki(input string name, input int got, input int exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, got, exp, $time);
    end
  endfunction

  // Reference model: one transaction, timed by cycles since acceptance (k=1 is the cycle after accept)
  logic [15:0] ref_mem [256];
  logic        m_busy = 1'b0, m_started = 1'b0, m_err = 1'b0;
  int          m_k = 0, m_lat = 0, m_rd_k = 0, m_wr_k = 0;
  logic [15:0] m_word = '0, m_wval = '0, m_rdata = '0;
  logic [15:0] mw, mv, mb;

  always @(posedge clock) begin
    if (m_busy && m_k == m_wr_k) ref_mem[m_word[7:0]] = m_wval;
    if (reset) begin
      m_busy = 1'b0;
      m_started = 1'b1;
    end else if (!m_busy) begin
      if (req_valid) begin
        mw = req_addr >> 1;
        m_word = mw;
        m_err = (!req_byte && req_addr[0]) || (mw >= 16'd256);
        m_rd_k = 0; m_wr_k = 0; m_rdata = '0; m_wval = '0;
        if (m_err) m_lat = 1;
        else begin
          mv = ref_mem[mw[7:0]];
          if (!req_we) begin
            m_lat = 3; m_rd_k = 1;
            mb = req_addr[0] ? (mv >> 8) : (mv & 16'h00FF);
            if (!req_byte) m_rdata = mv;
            else if (req_signed && mb >= 16'd128) m_rdata = mb + 16'hFF00;
            else m_rdata = mb;
          end else if (req_byte) begin
            m_lat = 4; m_rd_k = 1; m_wr_k = 3;
            m_wval = req_addr[0] ? ((mv & 16'h00FF) | (req_wdata << 8))
                                 : ((mv & 16'hFF00) | (req_wdata & 16'h00FF));
          end else begin
            m_lat = 2; m_wr_k = 1; m_wval = req_wdata;
          end
        end
        m_busy = 1'b1;
        m_k = 1;
      end
    end else if (m_k >= m_lat && resp_ready) m_busy = 1'b0;
    else m_k++;
  end

  logic e_rv, e_mr, e_mw;
  always @(negedge clock) begin
    if (m_started) begin
      e_rv = m_busy && m_k >= m_lat;
      e_mr = m_busy && m_k == m_rd_k;
      e_mw = m_busy && m_k == m_wr_k;
      chk1("req_ready", req_ready, !m_busy);
      chk1("resp_valid", resp_valid, e_rv);
      chk16("resp_rdata", resp_rdata, e_rv ? m_rdata : 16'h0000);
      chk1("resp_err", resp_err, e_rv && m_err);
      chk1("mem_read", mem_read, e_mr);
      chk1("mem_write", mem_write, e_mw);
      chk16("address", address, (e_mr || e_mw) ? m_word : 16'h0000);
      chk16("write_data", write_data, e_mw ? m_wval : 16'h0000);
    end
  end

  logic [15:0] rd;
  logic        er;
  int          lat;

  task automatic wait_resp(input logic bp, output logic [15:0] r, output logic e, output int l);
    l = 1;
    while (!resp_valid && l < 10) begin
      if (bp) resp_ready = ($urandom_range(0, 3) != 0);
      @(negedge clock);
      l++;
    end
    chk1("resp_timeout", resp_valid, 1'b1);
    r = resp_rdata;
    e = resp_err;
  endtask

  task automatic do_req(input logic we, input logic bt, input logic sg, input logic [15:0] a,
                        input logic [15:0] d, input logic bp,
                        output logic [15:0] r, output logic e, output int l);
    int n;
    n = 0;
    while (m_busy && n < 60) begin
      @(negedge clock);
      if (bp) resp_ready = ($urandom_range(0, 3) != 0);
      n++;
    end
    chk1("idle_timeout", m_busy, 1'b0);
    req_valid = 1'b1; req_we = we; req_byte = bt; req_signed = sg; req_addr = a; req_wdata = d;
    @(negedge clock);
    req_valid = 1'b0;
    req_we = 1'($urandom_range(0, 1)); req_byte = 1'($urandom_range(0, 1));
    req_addr = 16'($urandom); req_wdata = 16'($urandom);
    wait_resp(bp, r, e, l);
  endtask

  int rd0, wr0, sel;
  logic [15:0] ra;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, fails so far %0d", fails);
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) begin
      dmem[i] = '0;
      ref_mem[i] = '0;
    end
    repeat (2) @(negedge clock);
    chk1("rst_req_ready", req_ready, 1'b1);
    chk1("rst_resp_valid", resp_valid, 1'b0);
    chk1("rst_mem_read", mem_read, 1'b0);
    chk16("rst_address", address, 16'h0000);
    reset = 1'b0;

    // word store then word load
    do_req(1'b1, 1'b0, 1'b0, 16'h000A, 16'h33CC, 1'b0, rd, er, lat);
    chki("sw_latency", lat, 2);
    chk16("sw_address", last_wr_addr, 16'd5);
    chk16("sw_data", last_wr_data, 16'h33CC);
    do_req(1'b0, 1'b0, 1'b0, 16'h000A, 16'h0000, 1'b0, rd, er, lat);
    chki("lw_latency", lat, 3);
    chk16("lw_rdata", rd, 16'h33CC);
    chk1("lw_err", er, 1'b0);

    // byte loads of 0x80F1
    do_req(1'b1, 1'b0, 1'b0, 16'h000A, 16'h80F1, 1'b0, rd, er, lat);
    do_req(1'b0, 1'b1, 1'b1, 16'h000B, 16'h0000, 1'b0, rd, er, lat);
    chk16("lb_hi", rd, 16'hFF80);
    do_req(1'b0, 1'b1, 1'b0, 16'h000B, 16'h0000, 1'b0, rd, er, lat);
    chk16("lbu_hi", rd, 16'h0080);
    do_req(1'b0, 1'b1, 1'b1, 16'h000A, 16'h0000, 1'b0, rd, er, lat);
    chk16("lb_lo", rd, 16'hFFF1);

    // byte store read-modify-write
    do_req(1'b1, 1'b0, 1'b0, 16'h000A, 16'h1234, 1'b0, rd, er, lat);
    rd0 = n_rd; wr0 = n_wr;
    do_req(1'b1, 1'b1, 1'b0, 16'h000B, 16'h00AB, 1'b0, rd, er, lat);
    chki("sb_latency", lat, 4);
    chki("sb_reads", n_rd - rd0, 1);
    chki("sb_writes", n_wr - wr0, 1);
    chk16("sb_merged", last_wr_data, 16'hAB34);
    do_req(1'b0, 1'b0, 1'b0, 16'h000A, 16'h0000, 1'b0, rd, er, lat);
    chk16("sb_readback", rd, 16'hAB34);

    // misaligned and out-of-range
    rd0 = n_rd; wr0 = n_wr;
    do_req(1'b0, 1'b0, 1'b0, 16'h0003, 16'h0000, 1'b0, rd, er, lat);
    chki("mis_latency", lat, 1);
    chk1("mis_err", er, 1'b1);
    chk16("mis_rdata", rd, 16'h0000);
    do_req(1'b1, 1'b0, 1'b0, 16'h0200, 16'hBEEF, 1'b0, rd, er, lat);
    chki("oor_latency", lat, 1);
    chk1("oor_err", er, 1'b1);
    chki("err_no_access", (n_rd - rd0) + (n_wr - wr0), 0);

    // back-pressure with the next request already waiting
    @(negedge clock);
    resp_ready = 1'b0;
    do_req(1'b0, 1'b0, 1'b0, 16'h000A, 16'h0000, 1'b0, rd, er, lat);
    req_valid = 1'b1; req_we = 1'b0; req_byte = 1'b1; req_signed = 1'b0; req_addr = 16'h000B;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      chk1("bp_valid", resp_valid, 1'b1);
      chk16("bp_rdata", resp_rdata, 16'hAB34);
      chk1("bp_req_ready", req_ready, 1'b0);
    end
    resp_ready = 1'b1;
    @(negedge clock);
    chk1("hs_req_ready", req_ready, 1'b1);
    chk1("hs_resp_valid", resp_valid, 1'b0);
    @(negedge clock);
    chk1("acc_req_ready", req_ready, 1'b0);
    req_valid = 1'b0;
    wait_resp(1'b0, rd, er, lat);
    chki("bp_next_latency", lat, 3);
    chk16("bp_next_rdata", rd, 16'h00AB);

    // reset during RMW_MERGE drops the byte store
    do_req(1'b1, 1'b0, 1'b0, 16'h000E, 16'h5566, 1'b0, rd, er, lat);
    @(negedge clock);
    wr0 = n_wr;
    req_valid = 1'b1; req_we = 1'b1; req_byte = 1'b1; req_addr = 16'h000E; req_wdata = 16'h0099;
    @(negedge clock);
    req_valid = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    chk1("rst_mid_mem_write", mem_write, 1'b0);
    chk1("rst_mid_req_ready", req_ready, 1'b1);
    chk16("rst_mid_write_data", write_data, 16'h0000);
    @(negedge clock);
    chki("rst_mid_no_write", n_wr - wr0, 0);
    do_req(1'b0, 1'b0, 1'b0, 16'h000E, 16'h0000, 1'b0, rd, er, lat);
    chk16("rst_mid_word", rd, 16'h5566);

    // randomized traffic with random back-pressure
    for (int t = 0; t < 300; t++) begin
      sel = $urandom_range(0, 15);
      if (sel == 0) ra = 16'($urandom);
      else if (sel == 1) ra = 16'h01FC + 16'($urandom_range(0, 5));
      else ra = 16'($urandom_range(0, 511));
      do_req(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             ra, 16'($urandom), 1'b1, rd, er, lat);
    end
    resp_ready = 1'b1;
    repeat (3) @(negedge clock);

    for (int i = 0; i < 256; i++) chk16("mem_image", dmem[i], ref_mem[i]);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- MEM-stage controller between the execute stage and data_memory.
- Accepts one load/store request at a time from EX over a valid/ready handshake and converts byte addresses to 16-bit word addresses.
- Drives data_memory's address/write_data/mem_read/mem_write and consumes its registered read_data.
- Returns a formatted result to writeback over a second valid/ready handshake.
- Supports word and byte accesses; byte stores are done as read-modify-write; range and alignment errors are flagged.

Parameters:
- DEPTH_WORDS, 256, number of 16-bit words in the attached data_memory; word addresses >= DEPTH_WORDS are out of range.

Ports:
- clock  input  1  rising-edge clock shared with data_memory
- reset  input  1  synchronous, active-high reset
- req_valid  input  1  EX presents a request
- req_ready  output  1  LSU can accept a request (high only in IDLE)
- req_we  input  1  1 = store, 0 = load
- req_byte  input  1  1 = byte access, 0 = word access
- req_signed  input  1  byte loads only: 1 = sign-extend, 0 = zero-extend
- req_addr  input  16  byte address
- req_wdata  input  16  store data; byte stores use bits [7:0]
- resp_valid  output  1  response available
- resp_ready  input  1  writeback accepts the response
- resp_rdata  output  16  load result; 0 for stores and errors
- resp_err  output  1  request was misaligned or out of range
- address  output  16  to data_memory: word address {1'b0, addr[15:1]}
- write_data  output  16  to data_memory
- mem_read  output  1  to data_memory
- mem_write  output  1  to data_memory
- read_data  input  16  from data_memory; valid the cycle after an edge sampling mem_read=1

Behaviour:
- Reset values: state IDLE; req_ready=1 (IDLE); resp_valid=0, resp_rdata=0, resp_err=0; address=0, write_data=0, mem_read=0, mem_write=0; all captured request registers 0.
- Memory outputs are decoded from state and the captured request registers only. They never depend combinationally on req_* inputs.
- Little-endian byte lanes: addr[0]=0 selects bits [7:0], addr[0]=1 selects bits [15:8].
- IDLE: on req_valid & req_ready, capture we, byte, signed, addr, wdata, then check for errors.
  - Error if word access with addr[0]=1 (misaligned), or addr[15:1] >= DEPTH_WORDS (out of range).
  - On error go to RESP with resp_err=1 and resp_rdata=0; no memory access is made.
  - Otherwise: word store -> WRITE; load -> READ; byte store -> RMW_READ.
- READ (1 cycle): mem_read=1, address=word address -> CAPTURE.
- CAPTURE (1 cycle): register the formatted read_data into resp_rdata -> RESP.
  - Word load: read_data unchanged.
  - Byte load: selected lane, sign- or zero-extended to 16 bits.
- RMW_READ (1 cycle): mem_read=1 -> RMW_MERGE.
- RMW_MERGE (1 cycle): register the merged word, i.e. read_data with the selected lane replaced by wdata[7:0] -> WRITE.
- WRITE (1 cycle): mem_write=1; write_data = wdata (word store) or merged word (byte store) -> RESP with resp_rdata=0.
- RESP: resp_valid=1; resp_rdata and resp_err held stable until resp_ready.
  - On resp_valid & resp_ready -> IDLE; resp_valid, resp_rdata and resp_err clear on that edge.
- Latency from the accept edge to resp_valid high:
  - error: 1 cycle
  - word store: 2 cycles
  - load: 3 cycles
  - byte store: 4 cycles
- Throughput: one outstanding request. req_ready stays low from the accept edge until the response handshake completes, so no new request is accepted in the handshake cycle.
- mem_read and mem_write are never high together.
- Outside READ/RMW_READ/WRITE, address and write_data are 0.
- Reset mid-operation: return to IDLE on the reset edge and drop the request with no response. A memory write whose mem_write=1 coincides with the reset edge still completes in data_memory, since the memory has no reset. No partial RMW write is issued afterwards.
- Back-pressure: resp_ready held low keeps the LSU in RESP indefinitely with outputs stable.

Test Plan:
- Word store then word load: SW addr=0x000A data=0x33CC, then LW addr=0x000A. SW cycle drives address=5, mem_write=1. resp_rdata=0x33CC exactly 3 cycles after the LW accept; resp_err=0.
- Byte loads: memory word 5 = 0x80F1. LB addr=0x000B -> 0xFF80. LBU addr=0x000B -> 0x0080. LB addr=0x000A -> 0xFFF1.
- Byte store RMW: word 5 = 0x1234, SB addr=0x000B data=0x00AB. Bench sees mem_read (RMW_READ) then mem_write with write_data=0xAB34. A following LW of 0x000A returns 0xAB34.
- Errors: LW addr=0x0003 and SW addr=0x0200 (word 256 with DEPTH_WORDS=256) -> resp_err=1, resp_rdata=0, 1-cycle latency; mem_read and mem_write stay 0 throughout.
- Back-pressure: hold resp_ready=0 for 5 cycles after a load. resp_valid and resp_rdata stay stable; req_ready=0. With req_valid held high, the next request is accepted only the cycle after the response handshake.
- Reset mid byte-store: assert reset in RMW_MERGE -> no mem_write is issued. All outputs equal their reset values the cycle after; the memory word is unchanged.
